// File: rtl/aes_pkg.sv
// Shared AES helpers: key-size checks, round counts, FSM encoding, GF(2^8) helpers and the S-box table.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic bit key_bits_ok(input int kb);
    return (kb == 128) || (kb == 192) || (kb == 256);
  endfunction

  function automatic int nk_f(input int kb);
    return kb / 32;
  endfunction

  function automatic int nr_f(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k of the result is 0e*a[k] ^ 0b*a[k+1] ^ 0d*a[k+2] ^ 09*a[k+3] (indices mod 4)
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] me [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] m9 [4];
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      a     = c[31-8*k -: 8];
      x2    = xtime(a);
      x4    = xtime(x2);
      x8    = xtime(x4);
      me[k] = x8 ^ x4 ^ x2;
      mb[k] = x8 ^ x2 ^ a;
      md[k] = x8 ^ x4 ^ a;
      m9[k] = x8 ^ a;
    end
    for (int k = 0; k < 4; k++)
      r[31-8*k -: 8] = me[k] ^ mb[(k+1)%4] ^ md[(k+2)%4] ^ m9[(k+3)%4];
    return r;
  endfunction

  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [10:0] base;
    base = 11'd2047 - {a, 3'b000};
    return SBOX_TAB[base -: 8];
  endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// Key-load / round-key read bundle for aes_key_expand_seq.
// AES_EQINV_KEY_EN adds the equivalent-inverse round-key output rk_inv_out.
interface aes_key_expand_seq_if #(
  parameter int KEY_BITS = 256
);
  logic                key_valid;
  logic                key_ready;
  logic [KEY_BITS-1:0] key_in;
  logic                busy;
  logic                keys_valid;
  logic [3:0]          rk_idx;
  logic [127:0]        rk_out;
`ifdef AES_EQINV_KEY_EN
  logic [127:0]        rk_inv_out;

  modport master (output key_valid, key_in, rk_idx,
                  input  key_ready, busy, keys_valid, rk_out, rk_inv_out);
  modport slave  (input  key_valid, key_in, rk_idx,
                  output key_ready, busy, keys_valid, rk_out, rk_inv_out);
`else
  modport master (output key_valid, key_in, rk_idx,
                  input  key_ready, busy, keys_valid, rk_out);
  modport slave  (input  key_valid, key_in, rk_idx,
                  output key_ready, busy, keys_valid, rk_out);
`endif
endinterface

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: four byte-wide S-box lookups; also used by the cipher datapath.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign dout[8*b +: 8] = sbox(din[8*b +: 8]);
  end
endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key expansion, one word per cycle, with a random-access round-key read port.
// AES_EQINV_KEY_EN adds rk_inv_out (InvMixColumns round keys for the equivalent inverse cipher).
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_key_expand_seq_if.slave  kif
);
  localparam int NK = nk_f(KEY_BITS);
  localparam int NR = nr_f(NK);
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK_W   = 6'(NK);
  localparam logic [5:0] LAST_W = 6'(NW - 1);
  localparam logic [2:0] J_LAST = 3'(NK - 1);
  localparam logic [3:0] NR_W   = 4'(NR);

  if (!key_bits_ok(KEY_BITS)) begin : g_bad_key_bits
    $error("aes_key_expand_seq: KEY_BITS must be 128, 192 or 256");
  end

  state_e      state_q, state_d;
  logic [5:0]  i_q, i_d;
  logic [2:0]  j_q, j_d;
  logic [7:0]  rcon_q, rcon_d;
  logic        keys_valid_q, keys_valid_d;
  logic [31:0] w_q [NW];
  logic [31:0] w_d [NW];

  logic        key_ready, accept;
  logic [31:0] w_prev, w_back, sub_in, sub_out, t_word;

  assign key_ready      = (state_q != EXPAND);
  assign accept         = kif.key_valid && key_ready;
  assign kif.key_ready  = key_ready;
  assign kif.busy       = (state_q == EXPAND);
  assign kif.keys_valid = keys_valid_q;

  assign w_prev = w_q[i_q - 6'd1];
  assign w_back = w_q[i_q - NK_W];
  assign sub_in = (j_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sub_word u_sub_word (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    t_word = w_prev;
    if (j_q == 3'd0)
      t_word = sub_out ^ {rcon_q, 24'h0};
    else if (NK == 8 && j_q == 3'd4)
      t_word = sub_out;
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    rcon_d       = rcon_q;
    keys_valid_d = keys_valid_q;
    w_d          = w_q;
    unique case (state_q)
      EXPAND: begin
        w_d[i_q] = w_back ^ t_word;
        i_d      = i_q + 6'd1;
        j_d      = (j_q == J_LAST) ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0) rcon_d = xtime(rcon_q);
        if (i_q == LAST_W) state_d = DONE;
      end
      default: begin
        // keys_valid trails entry into DONE by one edge and drops with the next key load
        keys_valid_d = (state_q == DONE);
        if (accept) begin
          for (int k = 0; k < NK; k++) w_d[k] = kif.key_in[KEY_BITS-1-32*k -: 32];
          i_d          = NK_W;
          j_d          = 3'd0;
          rcon_d       = 8'h01;
          keys_valid_d = 1'b0;
          state_d      = EXPAND;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      i_q          <= '0;
      j_q          <= '0;
      rcon_q       <= '0;
      keys_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      rcon_q       <= rcon_d;
      keys_valid_q <= keys_valid_d;
    end
  end

  // Store is not reset; the read gate hides stale contents until keys_valid.
  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

  logic         rk_ok;
  logic [3:0]   rk_sel;
  logic [5:0]   rk_base;
  logic [127:0] rk_word;

  assign rk_ok      = keys_valid_q && (kif.rk_idx <= NR_W);
  assign rk_sel     = rk_ok ? kif.rk_idx : 4'd0;
  assign rk_base    = {rk_sel, 2'b00};
  assign rk_word    = rk_ok ? {w_q[rk_base], w_q[rk_base + 6'd1],
                               w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]} : '0;
  assign kif.rk_out = rk_word;

`ifdef AES_EQINV_KEY_EN
  logic [127:0] rk_imc;
  for (genvar c = 0; c < 4; c++) begin : g_imc
    assign rk_imc[127-32*c -: 32] = inv_mix_col(rk_word[127-32*c -: 32]);
  end
  assign kif.rk_inv_out = (rk_sel == 4'd0 || rk_sel == NR_W) ? rk_word : rk_imc;
`endif

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: one instance each of AES-128/192/256 against a FIPS-197 style model.
module tb_aes_key_expand_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  localparam logic [127:0] K128A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K128B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256A = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] K256B = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         kv_in [3];
  logic [255:0] key_a [3];
  logic [3:0]   idx_a [3];
  logic         rdy_o [3], busy_o [3], kvo [3];
  logic [127:0] rk_o  [3];

  aes_key_expand_seq_if #(.KEY_BITS(128)) kif0 ();
  aes_key_expand_seq_if #(.KEY_BITS(192)) kif1 ();
  aes_key_expand_seq_if #(.KEY_BITS(256)) kif2 ();

  aes_key_expand_seq #(.KEY_BITS(128)) dut0 (.clk(clk), .rst_n(rst_n), .kif(kif0));
  aes_key_expand_seq #(.KEY_BITS(192)) dut1 (.clk(clk), .rst_n(rst_n), .kif(kif1));
  aes_key_expand_seq #(.KEY_BITS(256)) dut2 (.clk(clk), .rst_n(rst_n), .kif(kif2));

  assign kif0.key_valid = kv_in[0]; assign kif0.key_in = key_a[0][255:128]; assign kif0.rk_idx = idx_a[0];
  assign kif1.key_valid = kv_in[1]; assign kif1.key_in = key_a[1][255:64];  assign kif1.rk_idx = idx_a[1];
  assign kif2.key_valid = kv_in[2]; assign kif2.key_in = key_a[2];          assign kif2.rk_idx = idx_a[2];
  assign rdy_o[0] = kif0.key_ready; assign busy_o[0] = kif0.busy; assign kvo[0] = kif0.keys_valid; assign rk_o[0] = kif0.rk_out;
  assign rdy_o[1] = kif1.key_ready; assign busy_o[1] = kif1.busy; assign kvo[1] = kif1.keys_valid; assign rk_o[1] = kif1.rk_out;
  assign rdy_o[2] = kif2.key_ready; assign busy_o[2] = kif2.busy; assign kvo[2] = kif2.keys_valid; assign rk_o[2] = kif2.rk_out;
`ifdef AES_EQINV_KEY_EN
  logic [127:0] inv_o [3];
  assign inv_o[0] = kif0.rk_inv_out; assign inv_o[1] = kif1.rk_inv_out; assign inv_o[2] = kif2.rk_inv_out;
`endif

  // ---------------- reference math ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl8(input logic [7:0] x, input int n);
    logic [7:0] y;
    y = x;
    for (int k = 0; k < n; k++) y = {y[6:0], y[7]};
    return y;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [31:0] imc_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0,8'h0e)^gmul(a1,8'h0b)^gmul(a2,8'h0d)^gmul(a3,8'h09),
            gmul(a0,8'h09)^gmul(a1,8'h0e)^gmul(a2,8'h0b)^gmul(a3,8'h0d),
            gmul(a0,8'h0d)^gmul(a1,8'h09)^gmul(a2,8'h0e)^gmul(a3,8'h0b),
            gmul(a0,8'h0b)^gmul(a1,8'h0d)^gmul(a2,8'h09)^gmul(a3,8'h0e)};
  endfunction

  function automatic logic [127:0] imc128(input logic [127:0] v);
    return {imc_col(v[127:96]), imc_col(v[95:64]), imc_col(v[63:32]), imc_col(v[31:0])};
  endfunction

  // Textbook key expansion: rcon taken by round number, i mod Nk selects the transform.
  function automatic logic [127:0] exp_rk(input logic [255:0] key, input int nk, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [79:0] rct;
    int nw;
    rct = 80'h01020408102040801b36;
    nw  = 4 * (nk + 7);
    for (int k = 0; k < nk; k++) w[k] = key[255-32*k -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0)                t = subw({t[23:0], t[31:24]}) ^ {rct[79-8*(i/nk-1) -: 8], 24'h0};
      else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic int nk_of(input int s);
    return (s == 0) ? 4 : (s == 1) ? 6 : 8;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- cycle model ----------------
  logic         m_busy [3], m_done [3], m_kv [3];
  int           m_cnt  [3];
  logic [255:0] m_key  [3];

  always @(posedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (!rst_n) begin
        m_busy[s] <= 1'b0; m_done[s] <= 1'b0; m_kv[s] <= 1'b0; m_cnt[s] <= 0; m_key[s] <= '0;
      end else if (!m_busy[s] && kv_in[s]) begin
        m_busy[s] <= 1'b1; m_done[s] <= 1'b0; m_kv[s] <= 1'b0; m_cnt[s] <= 1; m_key[s] <= key_a[s];
      end else if (m_busy[s]) begin
        m_cnt[s] <= m_cnt[s] + 1;
        if (m_cnt[s] == 4 * (nk_of(s) + 7) - nk_of(s)) begin
          m_busy[s] <= 1'b0; m_done[s] <= 1'b1;
        end
      end else if (m_done[s]) begin
        m_kv[s] <= 1'b1;
      end
    end
  end

  logic [127:0] cmp_e;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int s = 0; s < 3; s++) begin
        cmp_e = '0;
        if (m_kv[s] && int'(idx_a[s]) <= nk_of(s) + 6) cmp_e = exp_rk(m_key[s], nk_of(s), int'(idx_a[s]));
        chk($sformatf("cyc key_ready s%0d", s),  rdy_o[s],  !m_busy[s]);
        chk($sformatf("cyc busy s%0d", s),       busy_o[s], m_busy[s]);
        chk($sformatf("cyc keys_valid s%0d", s), kvo[s],    m_kv[s]);
        chk($sformatf("cyc rk_out s%0d idx%0d", s, idx_a[s]), rk_o[s], cmp_e);
`ifdef AES_EQINV_KEY_EN
        if (idx_a[s] != 4'd0 && int'(idx_a[s]) != nk_of(s) + 6) cmp_e = imc128(cmp_e);
        chk($sformatf("cyc rk_inv s%0d idx%0d", s, idx_a[s]), inv_o[s], cmp_e);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  int lat [3];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_lat(input logic [2:0] mask);
    logic [2:0] seen;
    int n;
    seen = '0; n = 0;
    for (int s = 0; s < 3; s++) lat[s] = -1;
    while ((seen & mask) != mask && n < 120) begin
      tick(); n++;
      for (int s = 0; s < 3; s++) begin
        idx_a[s] = 4'(n % 16);
        if (mask[s] && !seen[s] && kvo[s]) begin seen[s] = 1'b1; lat[s] = n; end
      end
    end
    for (int s = 0; s < 3; s++)
      if (mask[s]) chk($sformatf("keys_valid within bound s%0d", s), seen[s], 1'b1);
  endtask

  initial begin
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rl8(inv, 1) ^ rl8(inv, 2) ^ rl8(inv, 3) ^ rl8(inv, 4) ^ 8'h63;
    end
    chk("model sbox(00)", sb[0], 8'h63);
    chk("model sbox(53)", sb[8'h53], 8'hed);
    chk("model invmixcol", imc_col(32'h8e4da1bc), 32'hdb135345);

    for (int s = 0; s < 3; s++) begin kv_in[s] = 1'b0; key_a[s] = '0; idx_a[s] = 4'd0; end
    repeat (3) tick();
    chk_en = 1'b1;
    rst_n  = 1'b1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset key_ready s%0d", s), rdy_o[s], 1'b1);
      chk($sformatf("reset busy s%0d", s), busy_o[s], 1'b0);
      chk($sformatf("reset keys_valid s%0d", s), kvo[s], 1'b0);
    end

    // FIPS-197 keys on all three sizes, accepted on the same edge
    key_a[0] = {K128A, 128'h0}; key_a[1] = {K192, 64'h0}; key_a[2] = K256A;
    for (int s = 0; s < 3; s++) kv_in[s] = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) kv_in[s] = 1'b0;
    wait_lat(3'b111);
    chk("latency 128", lat[0], 41);
    chk("latency 192", lat[1], 47);
    chk("latency 256", lat[2], 53);
    idx_a[0] = 4'd10; idx_a[1] = 4'd12; idx_a[2] = 4'd14; #1;
    chk("aes128 rk10", rk_o[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("aes192 w51", rk_o[1][31:0], 32'h01002202);
    chk("aes256 w59", rk_o[2][31:0], 32'h706c631e);

    // key_valid held through EXPAND with a different key must be ignored
    key_a[2] = K256B; kv_in[2] = 1'b1;
    tick();
    key_a[2] = ~K256B;
    repeat (30) tick();
    chk("held key_ready low", rdy_o[2], 1'b0);
    kv_in[2] = 1'b0;
    wait_lat(3'b100);
    chk("held remaining latency", lat[2], 23);
    idx_a[2] = 4'd14; #1;
    chk("aes256 00..1f rk14", rk_o[2], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // new key while DONE
    key_a[0] = {K128B, 128'h0}; kv_in[0] = 1'b1;
    tick();
    kv_in[0] = 1'b0;
    chk("reload keys_valid drop", kvo[0], 1'b0);
    wait_lat(3'b001);
    chk("reload latency", lat[0], 41);
    idx_a[0] = 4'd1; #1;
    chk("aes128 00..0f rk1", rk_o[0], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
`ifdef AES_EQINV_KEY_EN
    chk("eqinv rk1", inv_o[0], imc128(128'hd6aa74fdd2af72fadaa678f1d6ab76fe));
    idx_a[0] = 4'd0; #1;
    chk("eqinv rk0 passthrough", inv_o[0], K128B);
`endif
    idx_a[0] = 4'd15; #1;
    chk("rk_idx 15 gated", rk_o[0], 128'h0);

    // reset in the middle of an expansion
    key_a[0] = {K128A, 128'h0}; kv_in[0] = 1'b1;
    tick();
    kv_in[0] = 1'b0;
    repeat (19) tick();
    rst_n = 1'b0;
    tick();
    chk("mid reset keys_valid", kvo[0], 1'b0);
    chk("mid reset busy", busy_o[0], 1'b0);
    rst_n = 1'b1;
    tick();
    chk("post reset key_ready", rdy_o[0], 1'b1);
    key_a[0] = {K128B, 128'h0}; kv_in[0] = 1'b1;
    tick();
    kv_in[0] = 1'b0;
    wait_lat(3'b001);
    chk("post reset latency", lat[0], 41);
    idx_a[0] = 4'd10; #1;
    chk("post reset rk10", rk_o[0], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
